accumulator_unit: RTL

//   Baby accumulator plus its operand/ALU sequencer. Latches a store word into the B operand register and drives the ALU inputs.

---
 rtl/accumulator_unit_pkg.sv | 21 ++
 rtl/accumulator_unit_if.sv | 29 ++
 rtl/accumulator_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/accumulator_unit_pkg.sv
// Shared encodings for the Baby accumulator slice: word width, opcodes, FSM states.
package accumulator_unit_pkg;

  localparam int unsigned BABY_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_LDN = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_EXECUTE,
    S_WRITEBACK,
    S_FINISH
  } state_e;

endpackage

// File: rtl/accumulator_unit_if.sv
// Control handshake and ALU operand/result bus around the accumulator.
interface accumulator_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] OPERAND;
  logic             BUSY;
  logic             DONE;
  logic             SKIP;
  logic             NEGATIVE;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic             ALU_SUB;
  logic             ALU_OE_n;
  logic [WIDTH-1:0] ALU_RESULT;

  // Accumulator side
  modport slave (
    input  START, OP, OPERAND, ALU_RESULT,
    output BUSY, DONE, SKIP, NEGATIVE, ALU_A, ALU_B, ALU_SUB, ALU_OE_n
  );

  // Control unit / ALU side
  modport master (
    output START, OP, OPERAND, ALU_RESULT,
    input  BUSY, DONE, SKIP, NEGATIVE, ALU_A, ALU_B, ALU_SUB, ALU_OE_n
  );
endinterface

// File: rtl/accumulator_unit.sv
// Baby accumulator and operand/ALU sequencer: LDN, SUB, CMP under START/DONE.
module accumulator_unit
  import accumulator_unit_pkg::*;
#(
  parameter int unsigned WIDTH         = BABY_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ACC_OE_n,
  output logic [WIDTH-1:0] DATA,
  accumulator_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic             zero_a_q;
  logic [3:0]       cnt_q;
  logic             skip_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control outputs decoded from the current state
  always_comb begin
    state_d      = state_q;
    bus.BUSY     = 1'b1;
    bus.DONE     = 1'b0;
    bus.ALU_SUB  = 1'b0;
    bus.ALU_OE_n = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        bus.BUSY = 1'b0;
        if (bus.START) begin
          if (op_e'(bus.OP) == OP_LDN || op_e'(bus.OP) == OP_SUB) state_d = S_LATCH;
          else                                                    state_d = S_FINISH;
        end
      end
      S_LATCH: begin
        bus.ALU_SUB = 1'b1;
        state_d     = S_EXECUTE;
      end
      S_EXECUTE: begin
        bus.ALU_SUB  = 1'b1;
        bus.ALU_OE_n = 1'b0;
        if (cnt_q == '0) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        bus.ALU_SUB  = 1'b1;
        bus.ALU_OE_n = 1'b0;
        state_d      = S_FINISH;
      end
      S_FINISH: begin
        bus.DONE = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, settle counter, compare flag and accumulator write-back
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q    <= '0;
      b_q      <= '0;
      zero_a_q <= 1'b0;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            case (op_e'(bus.OP))
              OP_LDN: begin
                b_q      <= bus.OPERAND;
                zero_a_q <= 1'b1;
                skip_q   <= 1'b0;
              end
              OP_SUB: begin
                b_q      <= bus.OPERAND;
                zero_a_q <= 1'b0;
                skip_q   <= 1'b0;
              end
              OP_CMP:  skip_q <= acc_q[WIDTH-1];
              default: skip_q <= 1'b0;
            endcase
          end
        end
        S_LATCH:     cnt_q <= 4'(SETTLE_CYCLES - 1);
        S_EXECUTE:   if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
        S_WRITEBACK: acc_q <= bus.ALU_RESULT;
        default: ;
      endcase
    end
  end

  // LDN is computed by the ALU as 0 - S, so A is forced to zero for the whole op
  assign bus.ALU_A    = zero_a_q ? '0 : acc_q;
  assign bus.ALU_B    = b_q;
  assign bus.NEGATIVE = acc_q[WIDTH-1];
  assign bus.SKIP     = bus.DONE & skip_q;
  assign DATA         = ACC_OE_n ? 'z : acc_q;

endmodule
